// File: rtl/div_unit.sv
// Sequential IEEE-754 single-precision divider, one restoring quotient bit per cycle.
// Shares the trig/vld/busy handshake and bus layout of the companion multiply unit.
module div_unit #(
  parameter int QBITS = 26
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] data1_in,
  input  logic [31:0] data2_in,
  output logic [31:0] data_out,
  input  logic        trig,
  output logic        vld,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIVIDE,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        mb_q, mb_d;
  logic [24:0]        rem_q, rem_d;
  logic [QBITS-1:0]   quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        res_q, res_d;
  logic [31:0]        data_out_q, data_out_d;
  logic               vld_q, vld_d;

  logic               a_zero, a_inf, a_nan;
  logic               b_zero, b_inf, b_nan;
  logic               s_res;
  logic [24:0]        diff;

  // Normalise, round to nearest-even, then saturate to inf or flush to zero.
  function automatic logic [31:0] round_pack(
    input logic              s,
    input logic signed [9:0] e_in,
    input logic [QBITS-1:0]  q,
    input logic              rem_nz
  );
    logic [23:0]       mant;
    logic              g;
    logic              st;
    logic signed [9:0] e;
    logic [24:0]       mant_inc;
    if (q[QBITS-1]) begin
      mant = q[QBITS-1:2];
      g    = q[1];
      st   = q[0] | rem_nz;
      e    = e_in;
    end else begin
      mant = q[QBITS-2:1];
      g    = q[0];
      st   = rem_nz;
      e    = e_in - 10'sd1;
    end
    mant_inc = {1'b0, mant} + {24'd0, g & (st | mant[0])};
    if (mant_inc[24]) begin
      mant = mant_inc[24:1];
      e    = e + 10'sd1;
    end else begin
      mant = mant_inc[23:0];
    end
    if (e >= 10'sd255)
      round_pack = {s, 8'hFF, 23'h0};
    else if (e <= 10'sd0)
      round_pack = {s, 31'h0};
    else
      round_pack = {s, e[7:0], mant[22:0]};
  endfunction

  assign a_zero = (a_q[30:23] == 8'h00);
  assign a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'h0);
  assign a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'h0);
  assign b_zero = (b_q[30:23] == 8'h00);
  assign b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'h0);
  assign b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'h0);
  assign s_res  = a_q[31] ^ b_q[31];
  assign diff   = rem_q - {1'b0, mb_q};

  assign data_out = data_out_q;
  assign vld      = vld_q;
  // The vld cycle still counts as busy so a trig landing on it is dropped.
  assign busy     = (state_q != S_IDLE) || vld_q;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    mb_d       = mb_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    data_out_d = data_out_q;
    vld_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig && !busy) begin
          a_d     = data1_in;
          b_d     = data2_in;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d = s_res;
        quo_d  = '0;
        cnt_d  = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          res_d   = QNAN;
          state_d = S_DONE;
        end else if (a_inf || b_zero) begin
          res_d   = {s_res, 8'hFF, 23'h0};
          state_d = S_DONE;
        end else if (a_zero || b_inf) begin
          res_d   = {s_res, 31'h0};
          state_d = S_DONE;
        end else begin
          rem_d   = {2'b01, a_q[22:0]};
          mb_d    = {1'b1, b_q[22:0]};
          exp_d   = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        // rem stays below 2*mb, so the difference always fits in 24 bits.
        if (rem_q >= {1'b0, mb_q}) begin
          quo_d = {quo_q[QBITS-2:0], 1'b1};
          rem_d = {diff[23:0], 1'b0};
        end else begin
          quo_d = {quo_q[QBITS-2:0], 1'b0};
          rem_d = {rem_q[23:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(QBITS - 1))
          state_d = S_ROUND;
      end
      S_ROUND: begin
        res_d   = round_pack(sign_q, exp_q, quo_q, rem_q != 25'd0);
        state_d = S_DONE;
      end
      S_DONE: begin
        data_out_d = res_q;
        vld_d      = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mb_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      data_out_q <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      mb_q       <= mb_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      data_out_q <= data_out_d;
      vld_q      <= vld_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: reset, normal and special divides, range limits,
// handshake robustness and mid-operation reset.
module tb_div_unit;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] data1_in;
  logic [31:0] data2_in;
  logic [31:0] data_out;
  logic        trig;
  logic        vld;
  logic        busy;

  int tests = 0;
  int fails = 0;

  div_unit dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .data1_in  (data1_in),
    .data2_in  (data2_in),
    .data_out  (data_out),
    .trig      (trig),
    .vld       (vld),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Launch one divide and wait (bounded) for vld; lat is -1 on timeout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(posedge sys_clk); #1;
    data1_in = a;
    data2_in = b;
    trig     = 1'b1;
    @(posedge sys_clk); #1;
    trig     = 1'b0;
    data1_in = 32'hDEAD_BEEF;
    data2_in = 32'h1234_5678;
    lat      = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge sys_clk); #1;
      if (vld) begin
        lat = i;
        break;
      end
    end
    res = data_out;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    trig      = 1'b0;
    data1_in  = 32'h0;
    data2_in  = 32'h0;
    repeat (3) @(posedge sys_clk);
    #1;
    tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL reset_data_out got=%h exp=%h", data_out, 32'h0); end
    tests++; if (vld !== 1'b0) begin fails++; $display("FAIL reset_vld got=%b exp=0", vld); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL post_reset_data_out got=%h exp=%h", data_out, 32'h0); end
    tests++; if (vld !== 1'b0) begin fails++; $display("FAIL post_reset_vld got=%b exp=0", vld); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_normal;
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] ve [3];
    logic [31:0] res;
    int          lat;
    va[0] = 32'h40C0_0000; vb[0] = 32'h4000_0000; ve[0] = 32'h4040_0000;
    va[1] = 32'h3F80_0000; vb[1] = 32'h4040_0000; ve[1] = 32'h3EAA_AAAB;
    va[2] = 32'hBF80_0000; vb[2] = 32'h4080_0000; ve[2] = 32'hBE80_0000;
    for (int k = 0; k < 3; k++) begin
      run_op(va[k], vb[k], res, lat);
      tests++; if (res !== ve[k]) begin fails++; $display("FAIL normal_result[%0d] got=%h exp=%h", k, res, ve[k]); end
      tests++; if (lat !== 29) begin fails++; $display("FAIL normal_latency[%0d] got=%0d exp=29", k, lat); end
    end
  endtask

  task automatic test_specials;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] ve [4];
    logic [31:0] res;
    int          lat;
    va[0] = 32'h3F80_0000; vb[0] = 32'h0000_0000; ve[0] = 32'h7F80_0000;
    va[1] = 32'h0000_0000; vb[1] = 32'h0000_0000; ve[1] = 32'h7FC0_0000;
    va[2] = 32'h7F80_0000; vb[2] = 32'hFF80_0000; ve[2] = 32'h7FC0_0000;
    va[3] = 32'h8000_0000; vb[3] = 32'h4000_0000; ve[3] = 32'h8000_0000;
    for (int k = 0; k < 4; k++) begin
      run_op(va[k], vb[k], res, lat);
      tests++; if (res !== ve[k]) begin fails++; $display("FAIL special_result[%0d] got=%h exp=%h", k, res, ve[k]); end
      tests++; if (lat !== 2) begin fails++; $display("FAIL special_latency[%0d] got=%0d exp=2", k, lat); end
    end
  endtask

  task automatic test_range;
    logic [31:0] res;
    int          lat;
    run_op(32'h7F7F_FFFF, 32'h0080_0000, res, lat);
    tests++; if (res !== 32'h7F80_0000) begin fails++; $display("FAIL overflow_result got=%h exp=%h", res, 32'h7F80_0000); end
    tests++; if (lat !== 29) begin fails++; $display("FAIL overflow_latency got=%0d exp=29", lat); end
    run_op(32'h0080_0000, 32'h7F7F_FFFF, res, lat);
    tests++; if (res !== 32'h0000_0000) begin fails++; $display("FAIL underflow_result got=%h exp=%h", res, 32'h0); end
    tests++; if (lat !== 29) begin fails++; $display("FAIL underflow_latency got=%0d exp=29", lat); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    int          lat;
    int          nv;
    logic        busy_ok;
    logic        busy_after;
    res        = 32'h0;
    lat        = -1;
    nv         = 0;
    busy_ok    = 1'b1;
    busy_after = 1'b1;
    @(posedge sys_clk); #1;
    data1_in = 32'h40C0_0000;
    data2_in = 32'h4000_0000;
    trig     = 1'b1;
    @(posedge sys_clk); #1;
    trig     = 1'b0;
    data1_in = 32'h3F80_0000;
    data2_in = 32'h4040_0000;
    for (int i = 1; i <= 60; i++) begin
      @(posedge sys_clk); #1;
      if (lat > 0 && i == lat + 1) busy_after = busy;
      if (vld) begin
        nv++;
        if (lat < 0) begin
          lat = i;
          res = data_out;
        end
      end
      if ((lat < 0 || lat == i) && !busy) busy_ok = 1'b0;
      // Retrigger mid-divide and again on the vld cycle; all must be dropped.
      trig = (i == 4) || (i == 9) || vld;
    end
    trig = 1'b0;
    tests++; if (nv !== 1) begin fails++; $display("FAIL b2b_vld_count got=%0d exp=1", nv); end
    tests++; if (res !== 32'h4040_0000) begin fails++; $display("FAIL b2b_result got=%h exp=%h", res, 32'h4040_0000); end
    tests++; if (lat !== 29) begin fails++; $display("FAIL b2b_latency got=%0d exp=29", lat); end
    tests++; if (busy_ok !== 1'b1) begin fails++; $display("FAIL b2b_busy_held got=%b exp=1", busy_ok); end
    tests++; if (busy_after !== 1'b0) begin fails++; $display("FAIL b2b_busy_after_vld got=%b exp=0", busy_after); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] res;
    int          lat;
    int          nv;
    @(posedge sys_clk); #1;
    data1_in = 32'h3F80_0000;
    data2_in = 32'h4040_0000;
    trig     = 1'b1;
    @(posedge sys_clk); #1;
    trig = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL abort_data_out got=%h exp=%h", data_out, 32'h0); end
    tests++; if (vld !== 1'b0) begin fails++; $display("FAIL abort_vld got=%b exp=0", vld); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy); end
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge sys_clk); #1;
      if (vld) nv++;
    end
    tests++; if (nv !== 0) begin fails++; $display("FAIL abort_stray_vld got=%0d exp=0", nv); end
    run_op(32'h40C0_0000, 32'h4000_0000, res, lat);
    tests++; if (res !== 32'h4040_0000) begin fails++; $display("FAIL abort_restart_result got=%h exp=%h", res, 32'h4040_0000); end
    tests++; if (lat !== 29) begin fails++; $display("FAIL abort_restart_latency got=%0d exp=29", lat); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_specials();
    test_range();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
